// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- asynchronous serial receiver with phase-accumulator baud timing.
//
// Recovers 5..8-bit LSB-first frames (optional parity, one checked stop bit)
// from an idle-high serial line and presents each byte with its error flags on
// a valid/ready interface.
//
// Optional build macro: UART_RX_MAJORITY_EN
//   defined   : every bit decision is the 2-of-3 majority of the samples taken
//               at tick counts 7, 8 and 9; decisions happen at count 9.
//   undefined : a single sample at tick count 8 is used.
//
// Ports:
//   i_sys_clk       system clock, all logic on the rising edge
//   i_sys_rst       asynchronous active-high reset
//   i_fre_cnt       accumulator increment, round(16*baud*2^32/f_clk)
//   i_rx_data_bit   data bits per frame (5..8), latched at frame start
//   i_parity_mode   0 odd, 1 even, 2 mark, 3 space, 4..7 none; latched at start
//   i_uart_rx       asynchronous serial input, idle high
//   i_rx_ready      consumer accepts the held byte
//   o_rx_data       received byte, right-aligned, unused upper bits 0
//   o_rx_valid      byte held, stays high until accepted
//   o_parity_err    parity mismatch for the held byte
//   o_frame_err     first stop bit sampled low for the held byte
//   o_overrun       one-cycle pulse: an unaccepted byte was overwritten
//   o_dbg_state     current receiver state (0 idle, 1 start, 2 data,
//                   3 parity, 4 stop, 5 break)
//
// Handshake: a byte is transferred on every rising clock edge where
// o_rx_valid and i_rx_ready are both high; o_rx_valid then drops on that edge
// unless a new frame completes in the same cycle. o_rx_valid never waits on
// i_rx_ready, and data/flags stay stable while o_rx_valid is high and no new
// frame completes.
// -----------------------------------------------------------------------------
module uart_rx #(
   parameter int OVERSAMPLE  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic        i_sys_clk,
   input  logic        i_sys_rst,
   input  logic [31:0] i_fre_cnt,
   input  logic [3:0]  i_rx_data_bit,
   input  logic [2:0]  i_parity_mode,
   input  logic        i_uart_rx,
   input  logic        i_rx_ready,
   output logic [7:0]  o_rx_data,
   output logic        o_rx_valid,
   output logic        o_parity_err,
   output logic        o_frame_err,
   output logic        o_overrun,
   output logic [2:0]  o_dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_BREAK  = 3'd5
   } state_t;

   localparam logic [3:0] SAMPLE_CNT = 4'(OVERSAMPLE / 2);

   // ---------------------------------------------------------------- sync
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rx_s;

   always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
      if (i_sys_rst) sync_q <= '1;
      else           sync_q <= {sync_q[SYNC_STAGES-2:0], i_uart_rx};
   end
   assign rx_s = sync_q[SYNC_STAGES-1];

   // ---------------------------------------------------------------- ticks
   // The carry out of the 32-bit add is the oversample tick.
   logic [31:0] acc_q;
   logic [32:0] acc_sum;
   logic        tick;

   assign acc_sum = {1'b0, acc_q} + {1'b0, i_fre_cnt};
   assign tick    = acc_sum[32];

   always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
      if (i_sys_rst) acc_q <= '0;
      else           acc_q <= acc_sum[31:0];
   end

   // ---------------------------------------------------------------- sampling
   logic [3:0] cnt_q;
   logic       bit_val;
   logic       sample_now;

`ifdef UART_RX_MAJORITY_EN
   // Early samples at counts 7 and 8; the decision is made at count 9
   // together with the live synchronized line.
   logic [1:0] early_q;

   always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
      if (i_sys_rst) begin
         early_q <= 2'b11;
      end else if (tick) begin
         if (cnt_q == SAMPLE_CNT - 4'd1) early_q[0] <= rx_s;
         if (cnt_q == SAMPLE_CNT)        early_q[1] <= rx_s;
      end
   end

   assign bit_val    = (early_q[0] & early_q[1]) | (early_q[0] & rx_s) | (early_q[1] & rx_s);
   assign sample_now = tick && (cnt_q == SAMPLE_CNT + 4'd1);
`else
   assign bit_val    = rx_s;
   assign sample_now = tick && (cnt_q == SAMPLE_CNT);
`endif

   // ---------------------------------------------------------------- FSM
   state_t     state_q, state_d;
   logic       start_frame, shift_en, par_chk, stop_chk;
   logic [2:0] bit_idx_q, last_idx_q, last_idx_d;
   logic [2:0] par_mode_q;
   logic [7:0] shift_q;
   logic       perr_q, ferr_q, done_q;
   logic       exp_par;

   always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
      if (i_sys_rst) state_q <= S_IDLE;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      start_frame = 1'b0;
      shift_en    = 1'b0;
      par_chk     = 1'b0;
      stop_chk    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (tick && !rx_s) begin
               state_d     = S_START;
               start_frame = 1'b1;
            end
         end
         S_START: begin
            // A start bit that is high again at mid-bit was a glitch.
            if (sample_now) state_d = bit_val ? S_IDLE : S_DATA;
         end
         S_DATA: begin
            if (sample_now) begin
               shift_en = 1'b1;
               if (bit_idx_q == last_idx_q)
                  state_d = par_mode_q[2] ? S_STOP : S_PARITY;
            end
         end
         S_PARITY: begin
            if (sample_now) begin
               par_chk = 1'b1;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (sample_now) begin
               stop_chk = 1'b1;
               state_d  = bit_val ? S_IDLE : S_BREAK;
            end
         end
         S_BREAK: begin
            if (rx_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign o_dbg_state = state_q;

   // Out-of-range widths are clamped so the data phase always terminates.
   always_comb begin
      if (i_rx_data_bit < 4'd5)      last_idx_d = 3'd4;
      else if (i_rx_data_bit > 4'd8) last_idx_d = 3'd7;
      else                           last_idx_d = 3'(i_rx_data_bit - 4'd1);
   end

   always_comb begin
      case (par_mode_q[1:0])
         2'd0:    exp_par = ~^shift_q;
         2'd1:    exp_par = ^shift_q;
         2'd2:    exp_par = 1'b1;
         default: exp_par = 1'b0;
      endcase
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
      if (i_sys_rst) begin
         cnt_q      <= '0;
         bit_idx_q  <= '0;
         last_idx_q <= 3'd7;
         par_mode_q <= 3'd4;
         shift_q    <= '0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= stop_chk;

         if (start_frame || state_q == S_IDLE || state_q == S_BREAK)
            cnt_q <= '0;
         else if (tick)
            cnt_q <= cnt_q + 4'd1;

         if (start_frame) begin
            last_idx_q <= last_idx_d;
            par_mode_q <= i_parity_mode;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
         end

         if (shift_en) begin
            shift_q[bit_idx_q] <= bit_val;
            bit_idx_q          <= bit_idx_q + 3'd1;
         end

         if (par_chk)  perr_q <= (bit_val != exp_par);
         if (stop_chk) ferr_q <= ~bit_val;
      end
   end

   // ---------------------------------------------------------------- output
   always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
      if (i_sys_rst) begin
         o_rx_data    <= '0;
         o_rx_valid   <= 1'b0;
         o_parity_err <= 1'b0;
         o_frame_err  <= 1'b0;
         o_overrun    <= 1'b0;
      end else begin
         o_overrun <= 1'b0;
         if (done_q) begin
            o_rx_data    <= shift_q;
            o_parity_err <= perr_q;
            o_frame_err  <= ferr_q;
            o_rx_valid   <= 1'b1;
            // Completing in the same cycle as an acceptance is not an overrun.
            o_overrun    <= o_rx_valid & ~i_rx_ready;
         end else if (o_rx_valid && i_rx_ready) begin
            o_rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx.
// Frames are built from data/width/parity rules; expected bytes and flags come
// from a small frame model and are queued, then matched by a monitor whenever a
// byte is accepted (o_rx_valid & i_rx_ready).
// -----------------------------------------------------------------------------
module tb_uart_rx;

   localparam int BIT_CLKS = 256;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] fre_cnt;
   logic [3:0]  data_bit;
   logic [2:0]  pmode;
   logic        rx_line;
   logic        rx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid, parity_err, frame_err, overrun;
   logic [2:0]  dbg_state;

   int checks      = 0;
   int failures    = 0;
   int frames_seen = 0;
   int frames_exp  = 0;
   int overrun_cnt = 0;

   logic [9:0] exp_q[$];   // {frame_err, parity_err, data}

   uart_rx dut (
      .i_sys_clk     (clk),
      .i_sys_rst     (rst),
      .i_fre_cnt     (fre_cnt),
      .i_rx_data_bit (data_bit),
      .i_parity_mode (pmode),
      .i_uart_rx     (rx_line),
      .i_rx_ready    (rx_ready),
      .o_rx_data     (rx_data),
      .o_rx_valid    (rx_valid),
      .o_parity_err  (parity_err),
      .o_frame_err   (frame_err),
      .o_overrun     (overrun),
      .o_dbg_state   (dbg_state)
   );

   // ---------------------------------------------------------------- clock/reset
   always #5 clk = ~clk;

   initial begin
      #990000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------- check helper
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // ---------------------------------------------------------------- model
   function automatic logic parity_rule(input logic [7:0] d, input int pm);
      int ones = $countones(d);
      case (pm)
         0:       return (ones % 2) == 0;   // odd: total ones odd
         1:       return (ones % 2) == 1;   // even: total ones even
         2:       return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [7:0] mask_data(input logic [7:0] d, input int nb);
      logic [8:0] m = (9'd1 << nb) - 9'd1;
      return d & m[7:0];
   endfunction

   function automatic logic [9:0] model(input logic [7:0] d, input int nb, input int pm,
                                        input logic par_bit, input logic stop);
      logic [7:0] md = mask_data(d, nb);
      logic       perr = (pm < 4) && (par_bit != parity_rule(md, pm));
      return {~stop, perr, md};
   endfunction

   // ---------------------------------------------------------------- monitor
   always @(negedge clk) begin
      if (!rst && rx_valid && rx_ready) begin
         frames_seen++;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL unexpected_frame observed=%0h expected=none", rx_data);
         end else begin
            logic [9:0] e;
            e = exp_q.pop_front();
            chk("rx_data", 32'(rx_data), 32'(e[7:0]));
            chk("parity_err", 32'(parity_err), 32'(e[8]));
            chk("frame_err", 32'(frame_err), 32'(e[9]));
         end
      end
      if (!rst && overrun) overrun_cnt++;
   end

   // ---------------------------------------------------------------- drivers
   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives one frame; the config inputs are scrambled during the start bit
   // to show that the receiver uses the values captured at frame start.
   task automatic send_frame(input logic [7:0] d, input int nb, input int pm,
                             input logic par_bit, input logic stop, input int stop_bits);
      @(negedge clk);
      data_bit = 4'(nb);
      pmode    = 3'(pm);
      rx_line  = 1'b0;
      wait_clks(BIT_CLKS / 2);
      data_bit = 4'($urandom_range(5, 8));
      pmode    = 3'($urandom_range(0, 7));
      wait_clks(BIT_CLKS / 2);
      for (int i = 0; i < nb; i++) begin
         rx_line = d[i];
         wait_clks(BIT_CLKS);
      end
      if (pm < 4) begin
         rx_line = par_bit;
         wait_clks(BIT_CLKS);
      end
      rx_line = stop;
      wait_clks(BIT_CLKS * stop_bits);
      rx_line = 1'b1;
      wait_clks(64);
   endtask

   task automatic expect_frame(input logic [7:0] d, input int nb, input int pm,
                               input logic par_bit, input logic stop);
      exp_q.push_back(model(d, nb, pm, par_bit, stop));
      frames_exp++;
   endtask

   task automatic good_frame(input logic [7:0] d, input int nb, input int pm);
      logic p = parity_rule(mask_data(d, nb), pm);
      expect_frame(d, nb, pm, p, 1'b1);
      send_frame(d, nb, pm, p, 1'b1, 1);
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(exp_q.size()), 32'd0);
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      int seen0;
      rst      = 1'b1;
      rx_line  = 1'b1;
      rx_ready = 1'b1;
      fre_cnt  = 32'h1000_0000;
      data_bit = 4'd8;
      pmode    = 3'd4;
      wait_clks(5);

      chk("rst_valid", 32'(rx_valid), 32'd0);
      chk("rst_data", 32'(rx_data), 32'd0);
      chk("rst_perr", 32'(parity_err), 32'd0);
      chk("rst_ferr", 32'(frame_err), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      chk("rst_state", 32'(dbg_state), 32'd0);
      rst = 1'b0;
      wait_clks(50);

      // 8N1 basic frame
      good_frame(8'hA5, 8, 4);
      drain("drain_8n1_a5");

      // 7E1 with correct and corrupted parity bit
      expect_frame(8'h35, 7, 1, 1'b0, 1'b1);
      send_frame(8'h35, 7, 1, 1'b0, 1'b1, 1);
      drain("drain_7e1_ok");
      expect_frame(8'h35, 7, 1, 1'b1, 1'b1);
      send_frame(8'h35, 7, 1, 1'b1, 1'b1, 1);
      drain("drain_7e1_bad");

      // Framing error followed by a long low line, then a clean frame
      seen0 = frames_seen;
      expect_frame(8'h5A, 8, 4, 1'b0, 1'b0);
      send_frame(8'h5A, 8, 4, 1'b0, 1'b0, 4);
      drain("drain_frame_err");
      chk("break_no_spurious", 32'(frames_seen - seen0), 32'd1);
      chk("break_exit_idle", 32'(dbg_state), 32'd0);
      good_frame(8'h3C, 8, 4);
      drain("drain_after_break");

      // Start-bit glitch is rejected
      seen0 = frames_seen;
      @(negedge clk);
      rx_line = 1'b0;
      wait_clks(64);
      rx_line = 1'b1;
      wait_clks(400);
      chk("glitch_state_idle", 32'(dbg_state), 32'd0);
      chk("glitch_no_frame", 32'(frames_seen - seen0), 32'd0);
      chk("glitch_valid_low", 32'(rx_valid), 32'd0);
      good_frame(8'h81, 8, 4);
      drain("drain_after_glitch");

      // Overrun: two frames with the consumer stalled
      rx_ready = 1'b0;
      send_frame(8'h11, 8, 4, 1'b0, 1'b1, 1);
      chk("held_valid_first", 32'(rx_valid), 32'd1);
      chk("held_data_first", 32'(rx_data), 32'h11);
      chk("no_overrun_first", 32'(overrun_cnt), 32'd0);
      send_frame(8'h22, 8, 4, 1'b0, 1'b1, 1);
      chk("overrun_once", 32'(overrun_cnt), 32'd1);
      chk("overrun_valid", 32'(rx_valid), 32'd1);
      chk("overrun_data", 32'(rx_data), 32'h22);
      expect_frame(8'h22, 8, 4, 1'b0, 1'b1);
      @(posedge clk);
      #1 rx_ready = 1'b1;
      wait_clks(2);
      chk("accept_clears_valid", 32'(rx_valid), 32'd0);
      chk("accept_keeps_data", 32'(rx_data), 32'h22);
      drain("drain_overrun");

      // Reset during the 4th data bit of 0xFF
      seen0 = frames_seen;
      @(negedge clk);
      data_bit = 4'd8;
      pmode    = 3'd4;
      rx_line  = 1'b0;
      wait_clks(BIT_CLKS);
      rx_line = 1'b1;
      wait_clks(3 * BIT_CLKS + BIT_CLKS / 2);
      rst = 1'b1;
      wait_clks(10);
      chk("midrst_state", 32'(dbg_state), 32'd0);
      chk("midrst_valid", 32'(rx_valid), 32'd0);
      rst = 1'b0;
      wait_clks(3000);
      chk("midrst_no_frame", 32'(frames_seen - seen0), 32'd0);
      chk("midrst_state_idle", 32'(dbg_state), 32'd0);
      good_frame(8'h42, 8, 4);
      drain("drain_after_reset");

      // Randomized frames: width, parity mode, parity corruption, stop error
      for (int k = 0; k < 6; k++) begin
         logic [7:0] d    = 8'($urandom_range(0, 255));
         int         nb   = $urandom_range(5, 8);
         int         pm   = $urandom_range(0, 7);
         logic       bad  = ($urandom_range(0, 3) == 0);
         logic       stop = ($urandom_range(0, 3) != 0);
         logic       p    = parity_rule(mask_data(d, nb), pm) ^ bad;
         expect_frame(d, nb, pm, p, stop);
         send_frame(d, nb, pm, p, stop, 1);
         drain("drain_random");
      end

      wait_clks(100);
      chk("final_overrun_total", 32'(overrun_cnt), 32'd1);
      chk("final_frames", 32'(frames_seen), 32'(frames_exp));
      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
